// File: rtl/clk_period_meter.sv
// Measures an asynchronous clk_in against clk: period, high time, lock and
// loss-of-activity detection, all in clk cycles.
module clk_period_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TOL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
    localparam logic [CNT_W:0]     TOL_V     = (CNT_W + 1)'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t state, state_n;

    logic s1, s2, s3;
    logic rise_c, fall_c;

    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   hi_cap, hi_cap_n;
    logic [CNT_W-1:0]   prev, prev_n;
    logic               has_prev, has_prev_n;
    logic [MATCH_W-1:0] match, match_n;
    logic [CNT_W-1:0]   period_n, high_time_n;
    logic               meas_valid_n, locked_n, timeout_n;

    logic [CNT_W:0] diff_c, abs_diff_c;
    logic           within_tol_c;

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;
    assign fall_c = ~s2 & s3;

    // One extra bit so the subtraction sign is visible without wrap
    assign diff_c       = {1'b0, cnt} - {1'b0, prev};
    assign abs_diff_c   = diff_c[CNT_W] ? ((CNT_W + 1)'(0) - diff_c) : diff_c;
    assign within_tol_c = (abs_diff_c <= TOL_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi_cap     <= '0;
            prev       <= '0;
            has_prev   <= 1'b0;
            match      <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hi_cap     <= hi_cap_n;
            prev       <= prev_n;
            has_prev   <= has_prev_n;
            match      <= match_n;
            period     <= period_n;
            high_time  <= high_time_n;
            meas_valid <= meas_valid_n;
            locked     <= locked_n;
            timeout    <= timeout_n;
        end
    end

    // Next-state and datapath; an edge arriving as cnt hits max wins over timeout
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        hi_cap_n     = hi_cap;
        prev_n       = prev;
        has_prev_n   = has_prev;
        match_n      = match;
        period_n     = period;
        high_time_n  = high_time;
        meas_valid_n = 1'b0;
        locked_n     = locked;
        timeout_n    = timeout;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (rise_c) begin
                    cnt_n   = CNT_ONE;
                    state_n = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                cnt_n = cnt + CNT_ONE;
                if (fall_c) begin
                    hi_cap_n = cnt;
                end
                if (rise_c) begin
                    period_n     = cnt;
                    high_time_n  = hi_cap;
                    meas_valid_n = 1'b1;
                    cnt_n        = CNT_ONE;
                    prev_n       = cnt;
                    has_prev_n   = 1'b1;
                    if (!has_prev || !within_tol_c) begin
                        match_n = '0;
                    end else if (match != MATCH_MAX) begin
                        match_n = match + MATCH_ONE;
                    end
                    locked_n = (match_n == MATCH_MAX);
                end else if (cnt == CNT_MAX) begin
                    state_n    = ST_TIMEOUT;
                    cnt_n      = cnt;
                    timeout_n  = 1'b1;
                    locked_n   = 1'b0;
                    match_n    = '0;
                    has_prev_n = 1'b0;
                end
            end

            ST_TIMEOUT: begin
                if (rise_c) begin
                    cnt_n     = CNT_ONE;
                    timeout_n = 1'b0;
                    state_n   = ST_MEASURE;
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with CNT_W=8 so timeout and max-period
// corners are reachable in a short run.
module tb_clk_period_meter;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clk_period_meter #(
        .CNT_W   (CNT_W),
        .LOCK_CNT(4),
        .TOL     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_in    (clk_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
        int l;
    } meas_t;

    typedef struct {
        bit rst;
        int hi;
        int lo;
        bit vld;
        int p;
        int h;
        bit l;
    } row_t;

    meas_t q[$];
    row_t  tbl[$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int last_mv_cyc = 0;
    int to_cyc      = 0;
    bit saw_timeout = 1'b0;

    // Capture every measurement and the first cycle timeout is seen
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (reset) begin
            saw_timeout = 1'b0;
        end else begin
            if (meas_valid) begin
                q.push_back('{p: int'(period), h: int'(high_time), l: int'(locked)});
                last_mv_cyc = cyc;
            end
            if (timeout && !saw_timeout) begin
                saw_timeout = 1'b1;
                to_cyc      = cyc;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_period"},     int'(period),     0);
        check({tag, "_high_time"},  int'(high_time),  0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_locked"},     int'(locked),     0);
        check({tag, "_timeout"},    int'(timeout),    0);
    endtask

    task automatic do_reset();
        clk_in = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drive_seg(input int hi, input int lo);
        clk_in = 1'b1;
        repeat (hi) @(negedge clk);
        clk_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic add_row(input bit rst, input int hi, input int lo,
                           input bit vld, input int p, input int h, input bit l);
        tbl.push_back('{rst: rst, hi: hi, lo: lo, vld: vld, p: p, h: h, l: l});
    endtask

    task automatic check_meas(input string tag, input int idx, input int p, input int h, input int l);
        if (idx < q.size()) begin
            check({tag, "_period"},    q[idx].p, p);
            check({tag, "_high_time"}, q[idx].h, h);
            check({tag, "_locked"},    q[idx].l, l);
        end else begin
            check({tag, "_present"}, 0, 1);
        end
    endtask

    initial begin
        int  n0;
        bit  found;

        reset  = 1'b1;
        clk_in = 1'b0;

        // Each row drives one clk_in cycle; the expected measurement is the one
        // closed by the rising edge that opens that row's cycle.
        // Divide-by-8, 50% duty
        add_row(1, 4, 4, 0,  0, 0, 0);
        add_row(0, 4, 4, 1,  8, 4, 0);
        add_row(0, 4, 4, 1,  8, 4, 0);
        add_row(0, 4, 4, 1,  8, 4, 0);
        add_row(0, 4, 4, 1,  8, 4, 0);
        add_row(0, 4, 4, 1,  8, 4, 1);
        add_row(0, 4, 4, 1,  8, 4, 1);
        // Period 10, high 3
        add_row(1, 3, 7, 0,  0, 0, 0);
        add_row(0, 3, 7, 1, 10, 3, 0);
        add_row(0, 3, 7, 1, 10, 3, 0);
        add_row(0, 3, 7, 1, 10, 3, 0);
        add_row(0, 3, 7, 1, 10, 3, 0);
        // Alternating 8/9 within tolerance, then a jump to 16
        add_row(1, 4, 4, 0,  0, 0, 0);
        add_row(0, 4, 5, 1,  8, 4, 0);
        add_row(0, 4, 4, 1,  9, 4, 0);
        add_row(0, 4, 5, 1,  8, 4, 0);
        add_row(0, 4, 4, 1,  9, 4, 0);
        add_row(0, 4, 5, 1,  8, 4, 1);
        add_row(0, 4, 4, 1,  9, 4, 1);
        add_row(0, 4, 5, 1,  8, 4, 1);
        add_row(0, 8, 8, 1,  9, 4, 1);
        add_row(0, 8, 8, 1, 16, 8, 0);
        add_row(0, 8, 8, 1, 16, 8, 0);
        add_row(0, 8, 8, 1, 16, 8, 0);
        add_row(0, 8, 8, 1, 16, 8, 0);
        add_row(0, 8, 8, 1, 16, 8, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            n0 = q.size();
            drive_seg(tbl[i].hi, tbl[i].lo);
            check($sformatf("row%0d_count", i), q.size() - n0, int'(tbl[i].vld));
            if (tbl[i].vld)
                check_meas($sformatf("row%0d", i), n0, tbl[i].p, tbl[i].h, int'(tbl[i].l));
        end

        // Timeout after losing a locked divide-by-8 input
        do_reset();
        repeat (6) drive_seg(4, 4);
        check("to_prelock_locked", int'(locked), 1);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (timeout) found = 1'b1;
        end
        check("to_seen", int'(found), 1);
        if (found) begin
            check("to_latency", to_cyc - last_mv_cyc, 255);
            check("to_locked", int'(locked), 0);
        end
        n0 = q.size();
        drive_seg(4, 4);
        check("to_recover_no_meas", q.size() - n0, 0);
        check("to_recover_timeout", int'(timeout), 0);
        drive_seg(4, 4);
        check("to_next_count", q.size() - n0, 1);
        check_meas("to_next", n0, 8, 4, 0);

        // Rising edge on the same cycle the counter reaches its maximum
        do_reset();
        n0 = q.size();
        repeat (3) drive_seg(100, 155);
        check("max_count", q.size() - n0, 2);
        check_meas("max_m1", n0, 255, 100, 0);
        check_meas("max_m2", n0 + 1, 255, 100, 0);
        check("max_no_timeout", int'(saw_timeout), 0);
        check("max_timeout_now", int'(timeout), 0);

        // Asynchronous reset in the middle of a locked period
        do_reset();
        repeat (6) drive_seg(4, 4);
        check("rst_prelock_locked", int'(locked), 1);
        clk_in = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero_outputs("rst_mid");
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        n0 = q.size();
        drive_seg(4, 4);
        check("rst_first_rise_no_meas", q.size() - n0, 0);
        repeat (2) drive_seg(4, 4);
        check("rst_count", q.size() - n0, 2);
        check_meas("rst_m1", n0, 8, 4, 0);
        check_meas("rst_m2", n0 + 1, 8, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures an incoming divided or external clock against the system clock. It reports the period and high time in `clk` cycles, flags loss of input activity, and declares lock when consecutive periods agree. It sits downstream of the clock-divider outputs or of an off-chip clock pin, and gives self-check and bring-up logic a cycle-accurate view of the divided clocks.

## Interface
- `CNT_W`, 16: width of the period, high-time and internal cycle counters.
- `LOCK_CNT`, 4: number of consecutive matching periods required to assert `locked` (1..15).
- `TOL`, 1: maximum absolute difference, in `clk` cycles, for two successive periods to count as matching.

- `clk`, in, 1: system clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `clk_in`, in, 1: measured clock; asynchronous to `clk`.
- `period`, out, CNT_W: last measured rise-to-rise interval in `clk` cycles.
- `high_time`, out, CNT_W: rise-to-fall interval belonging to the same cycle as `period`.
- `meas_valid`, out, 1: one-cycle pulse; `period` and `high_time` were updated this cycle.
- `locked`, out, 1: `LOCK_CNT` consecutive matching periods have been seen.
- `timeout`, out, 1: no rising edge arrived within 2^CNT_W−1 cycles.

## Operation
- **Synchronizer:** 2-flop synchronizer `s1`→`s2`, plus history flop `s3`.
  - `rise` = `s2` & ~`s3`.
  - `fall` = ~`s2` & `s3`.
- **IDLE** (the reset state):
  - `cnt` is held at 0.
  - On `rise`: `cnt` loads 1, go to MEASURE. No `meas_valid`.
- **MEASURE:**
  - `cnt` increments every cycle.
  - On `fall`: the internal `hi_cap` register loads `cnt`.
  - On `rise`:
    - `period` loads `cnt`.
    - `high_time` loads `hi_cap`.
    - `meas_valid` = 1.
    - `cnt` loads 1.
- **Timeout:** In MEASURE, if `cnt` == 2^CNT_W−1 and there is no `rise` this cycle, go to TIMEOUT.
  - Entering TIMEOUT: `timeout` = 1, `locked` = 0, match counter cleared, `cnt` frozen.
  - In TIMEOUT, on `rise`: `cnt` loads 1, `timeout` = 0, go to MEASURE. No `meas_valid`.
- **Simultaneous events:** If `rise` occurs in the same cycle `cnt` reaches max, the edge wins. A normal measurement is taken with `period` = 2^CNT_W−1, and there is no timeout.
- **Lock tracking:**
  - `prev` holds the previous `period`; `has_prev` is cleared by reset and by TIMEOUT.
  - On each measurement with `has_prev`, compare |new − `prev`| ≤ `TOL` using CNT_W+1-bit unsigned arithmetic.
  - On a match, `match` increments, saturating at `LOCK_CNT`.
  - On a miss, `match` = 0.
  - On a measurement without `has_prev`, `match` = 0.
  - `locked` is registered in the same cycle as `meas_valid` and equals (`match_next` == `LOCK_CNT`).
- **Output hold:** `period`, `high_time` and `locked` hold their values between measurements. `locked` is cleared only by a miss, by timeout or by reset.
- **Reset values:** on reset, all outputs and internal registers are 0 and the state is IDLE. Asserting reset mid-measurement discards the partial count. The first `rise` after reset is treated as in IDLE.

## Timing
- **Synchronizer latency:** `clk_in` rising, first sampled at `clk` edge k, gives `s1`=1 after k and `s2`=1 after k+1, so `rise` is combinationally true in the cycle after k+1.
- **Output latency:** `meas_valid`, `period`, `high_time` and `locked` update after edge k+2.
  - Total latency is 3 `clk` edges from sampling.
  - Latency is constant, so it cancels out of `period`.
- **Pulse width:** `meas_valid` is exactly 1 cycle wide. Back-to-back pulses are possible only if `period` = 1, which is unreachable through the synchronizer; the minimum measurable period is 2.
- **Timeout latency:** `timeout` asserts 2^CNT_W−1 cycles after the last `rise` (registered, one cycle after `cnt` reaches max).
- **Value range:** `high_time` is in the range 1..`period`−1 for any clean input. No division or overflow occurs, because `cnt` never wraps.

## Test plan
- **Divide-by-8 lock:** `clk_in` = `clk`/8, 50% duty. Each `meas_valid` gives `period`=8, `high_time`=4. `locked` rises together with the 5th `meas_valid` (1st has no prev, 2nd–5th match).
- **Duty cycle:** `clk_in` period 10, high 3. `period`=10, `high_time`=3 on every pulse after the first.
- **Tolerance and loss of lock:**
  - Alternating periods 8/9, `TOL`=1: `locked` asserts and stays high.
  - Switch to period 16: the first 16-cycle measurement drops `locked` to 0.
  - `locked` re-asserts 4 measurements after that.
- **Timeout:** `CNT_W`=8; lock onto period 8, then hold `clk_in` low.
  - `timeout`=1 and `locked`=0 exactly 255 cycles after the last `rise`.
  - On the next rising edge, `timeout` clears and no `meas_valid` is produced.
  - The following edge produces a normal measurement.
- **Edge/max collision:** `CNT_W`=8, `clk_in` period exactly 255. `meas_valid` with `period`=255, `timeout` stays 0.
- **Reset mid-measurement:** Pulse `reset` asynchronously mid-period while locked.
  - All outputs go to 0 immediately.
  - The first `rise` after release produces no `meas_valid`.
  - The second `rise` reports the correct `period`.
